// File: rtl/idea_subkey_sequencer.sv
// IDEA encryption subkey sequencer: streams NUM_SUBKEYS 16-bit subkeys from a 128-bit key over a valid/ready handshake.
// Optional build macro IDEA_SKSEQ_INDEX_EN adds the sk_index output.
module idea_subkey_sequencer #(
  parameter int NUM_SUBKEYS = 52,
  parameter int ROT         = 25
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key_in,
  input  logic         key_load,
  input  logic         abort,
  output logic         key_busy,
  output logic [15:0]  sk_data,
  output logic         sk_valid,
  input  logic         sk_ready,
  output logic         sk_last,
  output logic [3:0]   sk_round,
  output logic         done
`ifdef IDEA_SKSEQ_INDEX_EN
  ,
  output logic [5:0]   sk_index
`endif
);

  localparam int         ROT_MOD  = ROT % 128;
  localparam logic [5:0] LAST_IDX = 6'(NUM_SUBKEYS - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t       state_reg, state_next;
  logic [127:0] key_reg, key_next;
  logic [5:0]   index_reg, index_next;
  logic [2:0]   word_sel_reg, word_sel_next;
  logic [15:0]  words [8];
  logic         in_stream;
  logic         is_last;
  logic [5:0]   round_full;

  // A shift by the full width yields zero, so ROT_MOD == 0 degenerates to identity.
  function automatic logic [127:0] rotl(input logic [127:0] k);
    return (k << ROT_MOD) | (k >> (128 - ROT_MOD));
  endfunction

  // Word 0 is the most significant 16 bits of the key register.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_words
      assign words[gi] = key_reg[127 - 16*gi -: 16];
    end
  endgenerate

  assign in_stream  = (state_reg == STREAM);
  assign is_last    = (index_reg == LAST_IDX);
  assign round_full = index_reg / 6'd6;

  assign key_busy = (state_reg != IDLE);
  assign sk_valid = in_stream;
  assign sk_data  = in_stream ? words[word_sel_reg] : 16'h0000;
  assign sk_last  = in_stream & is_last;
  assign sk_round = in_stream ? round_full[3:0] : 4'd0;
  assign done     = (state_reg == DONE);

`ifdef IDEA_SKSEQ_INDEX_EN
  assign sk_index = in_stream ? index_reg : 6'd0;
`endif

  always_comb begin
    state_next    = state_reg;
    key_next      = key_reg;
    index_next    = index_reg;
    word_sel_next = word_sel_reg;
    case (state_reg)
      IDLE: begin
        if (key_load) begin
          key_next      = key_in;
          index_next    = 6'd0;
          word_sel_next = 3'd0;
          state_next    = STREAM;
        end
      end
      STREAM: begin
        // Abort wins over a transfer presented in the same cycle.
        if (abort) begin
          state_next = IDLE;
        end else if (sk_ready) begin
          index_next    = index_reg + 6'd1;
          word_sel_next = word_sel_reg + 3'd1;
          if (word_sel_reg == 3'd7) begin
            key_next = rotl(key_reg);
          end
          if (is_last) begin
            state_next = DONE;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      key_reg      <= '0;
      index_reg    <= '0;
      word_sel_reg <= '0;
    end else begin
      state_reg    <= state_next;
      key_reg      <= key_next;
      index_reg    <= index_next;
      word_sel_reg <= word_sel_next;
    end
  end

endmodule

// File: tb/tb_idea_subkey_sequencer.sv
// Self-checking bench for idea_subkey_sequencer: scoreboard of expected subkeys plus a table of known words.
module tb_idea_subkey_sequencer;

  localparam int NUM = 52;
  localparam int ROT = 25;
  localparam logic [127:0] KEY_A = 128'h0001_0002_0003_0004_0005_0006_0007_0008;
  localparam logic [127:0] KEY_B = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [127:0] key_in = '0;
  logic         key_load = 1'b0;
  logic         abort = 1'b0;
  logic         sk_ready = 1'b0;
  logic         key_busy, sk_valid, sk_last, done;
  logic [15:0]  sk_data;
  logic [3:0]   sk_round;
`ifdef IDEA_SKSEQ_INDEX_EN
  logic [5:0]   sk_index;
`endif

  idea_subkey_sequencer #(.NUM_SUBKEYS(NUM), .ROT(ROT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_in   (key_in),
    .key_load (key_load),
    .abort    (abort),
    .key_busy (key_busy),
    .sk_data  (sk_data),
    .sk_valid (sk_valid),
    .sk_ready (sk_ready),
    .sk_last  (sk_last),
    .sk_round (sk_round),
    .done     (done)
`ifdef IDEA_SKSEQ_INDEX_EN
    ,
    .sk_index (sk_index)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] data;
    logic        last;
    logic [3:0]  round;
  } exp_t;

  typedef struct {
    int          idx;
    logic [15:0] data;
    logic        last;
    logic [3:0]  round;
  } vec_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          xfer_cnt = 0;
  int          done_cnt = 0;
  int          first_cyc = 0;
  int          last_cyc = 0;
  int          done_cyc = 0;
  logic [15:0] obs_data [NUM];
  logic        obs_last [NUM];
  logic [3:0]  obs_round [NUM];
  logic        stall_prev = 1'b0;
  logic [15:0] stall_data = '0;
  vec_t        tbl [21];

  always @(posedge clk) cyc <= cyc + 1;

  // Transfers are recognised at the falling edge; they complete at the following rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev && sk_valid) chk("stall_hold", sk_data, stall_data);
      if (sk_valid && sk_ready && !abort) begin
        if (sbq.size() == 0) begin
          chk("unexpected_xfer", 1, 0);
        end else begin
          mon_e = sbq.pop_front();
          chk("sk_data", sk_data, mon_e.data);
          chk("sk_last", sk_last, mon_e.last);
          chk("sk_round", sk_round, mon_e.round);
        end
`ifdef IDEA_SKSEQ_INDEX_EN
        chk("sk_index", sk_index, xfer_cnt);
`endif
        if (xfer_cnt < NUM) begin
          obs_data[xfer_cnt]  = sk_data;
          obs_last[xfer_cnt]  = sk_last;
          obs_round[xfer_cnt] = sk_round;
        end
        if (xfer_cnt == 0) first_cyc = cyc;
        if (sk_last) last_cyc = cyc;
        $display("xfer %0d data=%h last=%0b round=%0d", xfer_cnt, sk_data, sk_last, sk_round);
        xfer_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_valid_low", sk_valid, 0);
      end
      stall_prev = sk_valid && !sk_ready && !abort;
      stall_data = sk_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_expected(input logic [127:0] key);
    logic [127:0] k;
    logic [127:0] r;
    exp_t e;
    k = key;
    for (int i = 0; i < NUM; i++) begin
      e.data  = k[127 - 16*(i % 8) -: 16];
      e.last  = (i == NUM - 1);
      e.round = 4'(i / 6);
      sbq.push_back(e);
      if (i % 8 == 7) begin
        for (int b = 0; b < 128; b++) r[(b + ROT) % 128] = k[b];
        k = r;
      end
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, key_busy, 0);
    chk({tag, "_valid"}, sk_valid, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_data"}, sk_data, 0);
    chk({tag, "_last"}, sk_last, 0);
    chk({tag, "_round"}, sk_round, 0);
  endtask

  task automatic start_stream(input logic [127:0] key);
    key_in   = key;
    key_load = 1'b1;
    xfer_cnt = 0;
    push_expected(key);
    tick();
    key_load = 1'b0;
    chk("load_latency_valid", sk_valid, 1);
    chk("load_busy", key_busy, 1);
  endtask

  task automatic wait_xfer(input int n, input int budget);
    int c;
    c = 0;
    while (xfer_cnt < n && c < budget) begin
      tick();
      c++;
    end
    if (xfer_cnt < n) chk("timeout_xfer", xfer_cnt, n);
  endtask

  task automatic run_to_done(input int budget, input bit rnd);
    int d0;
    int c;
    d0 = done_cnt;
    c = 0;
    while (done_cnt == d0 && c < budget) begin
      if (rnd) sk_ready = 1'($urandom_range(0, 1));
      tick();
      c++;
    end
    if (done_cnt == d0) chk("timeout_done", 0, 1);
    sk_ready = 1'b1;
    chk("end_busy", key_busy, 0);
    chk("end_valid", sk_valid, 0);
    chk("xfer_count", xfer_cnt, NUM);
    chk("sbq_empty", sbq.size(), 0);
    chk("done_latency", done_cyc, last_cyc + 1);
    if (!rnd) chk("throughput", last_cyc - first_cyc, NUM - 1);
    repeat (3) tick();
    chk("done_once", done_cnt - d0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int d0;
    tbl[0]  = '{0,  16'h0001, 1'b0, 4'd0};
    tbl[1]  = '{1,  16'h0002, 1'b0, 4'd0};
    tbl[2]  = '{2,  16'h0003, 1'b0, 4'd0};
    tbl[3]  = '{3,  16'h0004, 1'b0, 4'd0};
    tbl[4]  = '{4,  16'h0005, 1'b0, 4'd0};
    tbl[5]  = '{5,  16'h0006, 1'b0, 4'd0};
    tbl[6]  = '{6,  16'h0007, 1'b0, 4'd1};
    tbl[7]  = '{7,  16'h0008, 1'b0, 4'd1};
    tbl[8]  = '{8,  16'h0400, 1'b0, 4'd1};
    tbl[9]  = '{9,  16'h0600, 1'b0, 4'd1};
    tbl[10] = '{10, 16'h0800, 1'b0, 4'd1};
    tbl[11] = '{11, 16'h0A00, 1'b0, 4'd1};
    tbl[12] = '{12, 16'h0C00, 1'b0, 4'd2};
    tbl[13] = '{13, 16'h0E00, 1'b0, 4'd2};
    tbl[14] = '{14, 16'h1000, 1'b0, 4'd2};
    tbl[15] = '{15, 16'h0200, 1'b0, 4'd2};
    tbl[16] = '{47, 16'hE001, 1'b0, 4'd7};
    tbl[17] = '{48, 16'h0080, 1'b0, 4'd8};
    tbl[18] = '{49, 16'h00C0, 1'b0, 4'd8};
    tbl[19] = '{50, 16'h0100, 1'b0, 4'd8};
    tbl[20] = '{51, 16'h0140, 1'b1, 4'd8};

    // Reset state
    #1 rst_n = 1'b0;
    #2 chk_quiet("reset");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    chk_quiet("idle");

    // Full run with sk_ready held high, then known-answer table
    sk_ready = 1'b1;
    start_stream(KEY_A);
    run_to_done(200, 1'b0);
    for (int i = 0; i < 21; i++) begin
      chk($sformatf("tbl_data_%0d", tbl[i].idx), obs_data[tbl[i].idx], tbl[i].data);
      chk($sformatf("tbl_last_%0d", tbl[i].idx), obs_last[tbl[i].idx], tbl[i].last);
      chk($sformatf("tbl_round_%0d", tbl[i].idx), obs_round[tbl[i].idx], tbl[i].round);
    end

    // Random back-pressure
    start_stream(KEY_A);
    run_to_done(2000, 1'b1);

    // key_load mid-stream is ignored
    start_stream(KEY_A);
    wait_xfer(10, 200);
    key_in   = KEY_B;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    run_to_done(200, 1'b0);

    // Abort at index 20
    start_stream(KEY_A);
    wait_xfer(20, 200);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", sk_valid, 0);
    chk("abort_busy", key_busy, 0);
    chk("abort_done", done, 0);
    sbq.delete();
    d0 = done_cnt;
    repeat (3) tick();
    chk("abort_no_done", done_cnt - d0, 0);

    // Restart with abort also high: abort has no effect in IDLE
    abort = 1'b1;
    start_stream(KEY_A);
    abort = 1'b0;
    run_to_done(200, 1'b0);

    // Asynchronous reset at index 30
    start_stream(KEY_A);
    wait_xfer(30, 200);
    #2 rst_n = 1'b0;
    #1 chk_quiet("midreset");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    sbq.delete();
    d0 = done_cnt;
    repeat (4) tick();
    chk("postreset_busy", key_busy, 0);
    chk("postreset_valid", sk_valid, 0);
    chk("postreset_no_done", done_cnt - d0, 0);

    // Fresh run with a different key after reset
    start_stream(KEY_B);
    run_to_done(200, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/idea_subkey_sequencer.md
IDEA_SUBKEY_SEQUENCER -- requirements
Module: idea_subkey_sequencer

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter NUM_SUBKEYS, default 52, SHALL set the number of 16-bit subkeys streamed per key.
REQ-003 Parameter ROT, default 25, SHALL set the left-rotate amount applied to the 128-bit key register after every 8th subkey.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 key_in  input  128  user key; bit 127 is the MSB of subkey 0.
REQ-007 key_load  input  1  request to capture key_in; honoured only in IDLE.
REQ-008 abort  input  1  synchronous cancel of the current stream.
REQ-009 key_busy  output  1  high in every state except IDLE.
REQ-010 sk_data  output  16  current subkey.
REQ-011 sk_valid  output  1  sk_data is valid.
REQ-012 sk_ready  input  1  consumer accepts sk_data; transfer = sk_valid & sk_ready at a rising edge.
REQ-013 sk_last  output  1  high with sk_valid when the index equals NUM_SUBKEYS-1.
REQ-014 sk_round  output  4  round number, index/6 (0..8).
REQ-015 done  output  1  one-cycle pulse after the final transfer.

Function
REQ-016 The FSM SHALL have the states IDLE, STREAM and DONE, with DONE lasting exactly one cycle.
REQ-017 IDLE with key_load=1 at an edge SHALL capture key_in into key_reg, clear index and word_sel, and enter STREAM, so sk_valid is high in the next cycle (latency 1).
REQ-018 In STREAM, sk_data SHALL equal key_reg[127-16*word_sel -: 16], a pure register mux with no extra latency.
REQ-019 Each transfer SHALL increment index and word_sel; a transfer at word_sel=7 SHALL wrap word_sel to 0 and rotate key_reg left by ROT (modulo 128) in the same edge.
REQ-020 sk_data SHALL be held stable while sk_valid=1 and sk_ready=0.
REQ-021 With sk_ready held high, the block SHALL complete one transfer per cycle, NUM_SUBKEYS transfers in NUM_SUBKEYS cycles.
REQ-022 The transfer with sk_last=1 SHALL move the FSM to DONE, which drives sk_valid=0 and done=1 and then returns to IDLE.
REQ-023 key_load SHALL be ignored in STREAM and DONE, and key_reg SHALL be unchanged by it.
REQ-024 abort=1 in STREAM SHALL force IDLE at the next edge with sk_valid=0 and no done pulse; abort SHALL take priority over a simultaneous transfer.
REQ-025 abort SHALL have no effect in IDLE or DONE.
REQ-026 sk_valid, sk_last and sk_round SHALL be 0 whenever the FSM is not in STREAM.

Reset
REQ-027 rst_n=0 SHALL, asynchronously, force IDLE, key_reg=0, index=0, word_sel=0, sk_valid=0, done=0, key_busy=0 and sk_data=0.
REQ-028 Reset asserted mid-stream SHALL discard the stream, and no done pulse SHALL follow after reset release.

Configuration
REQ-029 With macro IDEA_SKSEQ_INDEX_EN defined, an extra output sk_index (6 bits) SHALL present the current subkey index 0..NUM_SUBKEYS-1, valid with sk_valid and 0 otherwise.
REQ-030 Without IDEA_SKSEQ_INDEX_EN, the sk_index port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 Scenario: key_in=0x0001_0002_0003_0004_0005_0006_0007_0008, sk_ready=1 -> subkeys 0..15 = 0001..0008, 0400,0600,0800,0A00,0C00,0E00,1000,0200.
REQ-032 Scenario: same key, full run -> 52 transfers, sk_last only on the 52nd, sk_round 8 for indices 48..51, and done pulsed one cycle later.
REQ-033 Scenario: sk_ready toggled 0/1 randomly -> the identical 52-word sequence, with sk_data stable during every stall.
REQ-034 Scenario: abort at index 20 with sk_ready=1 -> next cycle IDLE, sk_valid=0, no done pulse; a new key_load restarts at index 0.
REQ-035 Scenario: key_load pulsed with a different key at index 10 -> ignored, and the stream continues with the original key.
REQ-036 Scenario: rst_n low for 2 cycles at index 30 -> all outputs 0 immediately, IDLE after release, no done pulse.
